// File: rtl/calc_input_sequencer.sv
// ----------------------------------------------------------------------------
// calc_input_sequencer
//
// Upstream control stage of the calculator. It conditions the three
// front-panel buttons and walks the operator through operand A, operand B and
// opcode entry from the switches. It drives the operands and opcode of the
// external combinational ALU and captures the ALU result and flags. It also
// produces the value and the hex/decimal select for the display driver.
//
// Parameters
//   WIDTH      operand/result width in bits (at most 32)
//   DB_CYCLES  stable cycles a synchronized button must hold before its
//              debounced level changes
//
// Ports
//   CLK          system clock
//   RESET        synchronous, active-high reset
//   SW           operand/opcode switches (asynchronous, not debounced)
//   BTN_ENTER    raw button: advance state
//   BTN_UNDO     raw button: step back one state
//   BTN_MODE     raw button: toggle hex/decimal display
//   ALU_RESULT   combinational ALU result for OP_A/OP_B/OPCODE
//   ALU_FLAGS    ALU flags {N,Z,C,V}
//   OP_A, OP_B   registered operands
//   OPCODE       registered opcode
//   BIN_OUT      32-bit value to the display driver (zero-extended)
//   HEX_TRIGGER  1 = hex display, 0 = decimal display
//   FLAGS_OUT    flags captured together with the result
//   STATE_LEDS   one-hot current state {RES,CALC,OP,B,A}
// ----------------------------------------------------------------------------
module calc_input_sequencer #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW,
  input  logic             BTN_ENTER,
  input  logic             BTN_UNDO,
  input  logic             BTN_MODE,
  input  logic [WIDTH-1:0] ALU_RESULT,
  input  logic [3:0]       ALU_FLAGS,
  output logic [WIDTH-1:0] OP_A,
  output logic [WIDTH-1:0] OP_B,
  output logic [1:0]       OPCODE,
  output logic [31:0]      BIN_OUT,
  output logic             HEX_TRIGGER,
  output logic [3:0]       FLAGS_OUT,
  output logic [4:0]       STATE_LEDS
);

  // --------------------------------------------------------------------------
  // State encoding: one-hot, so the state register drives the LEDs directly.
  // --------------------------------------------------------------------------
  typedef enum logic [4:0] {
    S_A    = 5'b00001,
    S_B    = 5'b00010,
    S_OP   = 5'b00100,
    S_CALC = 5'b01000,
    S_RES  = 5'b10000
  } state_t;

  // Button lane indices within the packed conditioning vectors.
  localparam int unsigned NUM_BTN   = 3;
  localparam int unsigned IDX_ENTER = 0;
  localparam int unsigned IDX_UNDO  = 1;
  localparam int unsigned IDX_MODE  = 2;

  localparam int          CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Button conditioning
  // --------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] armed;
  logic [NUM_BTN-1:0] pulse;
  logic [CW-1:0]      db_cnt [NUM_BTN];
  logic [1:0]         sync_valid;

  assign btn_raw = {BTN_MODE, BTN_UNDO, BTN_ENTER};

  // A button only produces pulses once it has been seen released after reset.
  // sync_valid marks when sync2 carries a real post-reset sample, so a button
  // held through reset stays disarmed until its debounced level is low with
  // the button actually released.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1      <= '0;
      sync2      <= '0;
      level      <= '0;
      level_q    <= '0;
      armed      <= '0;
      pulse      <= '0;
      sync_valid <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      sync_valid <= {sync_valid[0], 1'b1};
      level_q    <= level;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == CNT_MAX) begin
            level[i]  <= ~level[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end

        if (sync_valid[1] && !sync2[i] && !level[i]) begin
          armed[i] <= 1'b1;
        end

        pulse[i] <= armed[i] & level[i] & ~level_q[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command decode: UNDO takes priority over a coincident ENTER.
  // --------------------------------------------------------------------------
  logic enter_cmd;
  logic undo_cmd;
  logic mode_cmd;

  assign undo_cmd  = pulse[IDX_UNDO];
  assign enter_cmd = pulse[IDX_ENTER] & ~pulse[IDX_UNDO];
  assign mode_cmd  = pulse[IDX_MODE];

  // --------------------------------------------------------------------------
  // State machine next-state logic
  // --------------------------------------------------------------------------
  state_t state;
  state_t state_next;

  always_comb begin
    state_next = state;
    case (state)
      S_A: begin
        if (enter_cmd) state_next = S_B;
      end
      S_B: begin
        if (undo_cmd)       state_next = S_A;
        else if (enter_cmd) state_next = S_OP;
      end
      S_OP: begin
        if (undo_cmd)       state_next = S_B;
        else if (enter_cmd) state_next = S_CALC;
      end
      S_CALC: begin
        state_next = S_RES;
      end
      S_RES: begin
        if (undo_cmd)       state_next = S_OP;
        else if (enter_cmd) state_next = S_A;
      end
      default: begin
        state_next = S_A;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Display value selection (registered below)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] result;
  logic [31:0]      bin_next;

  always_comb begin
    bin_next = '0;
    case (state)
      S_A, S_B: bin_next[WIDTH-1:0] = SW;
      S_OP:     bin_next[1:0]       = SW[1:0];
      default:  bin_next[WIDTH-1:0] = result;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_A;
      OP_A        <= '0;
      OP_B        <= '0;
      OPCODE      <= '0;
      result      <= '0;
      FLAGS_OUT   <= '0;
      HEX_TRIGGER <= 1'b1;
      BIN_OUT     <= '0;
    end else begin
      state   <= state_next;
      BIN_OUT <= bin_next;

      if (mode_cmd) begin
        HEX_TRIGGER <= ~HEX_TRIGGER;
      end

      case (state)
        S_A: begin
          if (enter_cmd) OP_A <= SW;
        end
        S_B: begin
          if (enter_cmd) OP_B <= SW;
        end
        S_OP: begin
          if (enter_cmd) OPCODE <= SW[1:0];
        end
        S_CALC: begin
          result    <= ALU_RESULT;
          FLAGS_OUT <= ALU_FLAGS;
        end
        S_RES: begin
          // Flags are left as captured; only operands, opcode and result clear.
          if (enter_cmd) begin
            OP_A   <= '0;
            OP_B   <= '0;
            OPCODE <= '0;
            result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign STATE_LEDS = state;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// ----------------------------------------------------------------------------
// tb_calc_input_sequencer
//
// Directed bench for calc_input_sequencer with WIDTH=16, DB_CYCLES=4. A small
// ALU model (0 add, 1 sub, 2 and, 3 or) closes the loop from OP_A/OP_B/OPCODE
// to ALU_RESULT/ALU_FLAGS. Expected calculation results are queued when the
// opcode is entered and compared once the design reaches the result state.
// ----------------------------------------------------------------------------
module tb_calc_input_sequencer;

  localparam int W  = 16;
  localparam int DB = 4;

  localparam logic [4:0] L_A    = 5'b00001;
  localparam logic [4:0] L_B    = 5'b00010;
  localparam logic [4:0] L_OP   = 5'b00100;
  localparam logic [4:0] L_CALC = 5'b01000;
  localparam logic [4:0] L_RES  = 5'b10000;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [W-1:0]  SW;
  logic          BTN_ENTER;
  logic          BTN_UNDO;
  logic          BTN_MODE;
  logic [W-1:0]  ALU_RESULT;
  logic [3:0]    ALU_FLAGS;
  logic [W-1:0]  OP_A;
  logic [W-1:0]  OP_B;
  logic [1:0]    OPCODE;
  logic [31:0]   BIN_OUT;
  logic          HEX_TRIGGER;
  logic [3:0]    FLAGS_OUT;
  logic [4:0]    STATE_LEDS;

  int total = 0;
  int bad   = 0;
  int calc_seen = 0;

  typedef struct {
    logic [31:0] bin;
    logic [3:0]  flags;
  } exp_t;
  exp_t sb[$];

  calc_input_sequencer #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SW         (SW),
    .BTN_ENTER  (BTN_ENTER),
    .BTN_UNDO   (BTN_UNDO),
    .BTN_MODE   (BTN_MODE),
    .ALU_RESULT (ALU_RESULT),
    .ALU_FLAGS  (ALU_FLAGS),
    .OP_A       (OP_A),
    .OP_B       (OP_B),
    .OPCODE     (OPCODE),
    .BIN_OUT    (BIN_OUT),
    .HEX_TRIGGER(HEX_TRIGGER),
    .FLAGS_OUT  (FLAGS_OUT),
    .STATE_LEDS (STATE_LEDS)
  );

  always #5 CLK = ~CLK;

  // ALU model: flags {N,Z,C,V}; C is carry for add, borrow for sub.
  logic [W:0] alu_wide;
  logic       alu_c;
  logic       alu_v;
  always_comb begin
    alu_wide = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (OPCODE)
      2'd0: begin
        alu_wide = {1'b0, OP_A} + {1'b0, OP_B};
        alu_c    = alu_wide[W];
        alu_v    = (OP_A[W-1] == OP_B[W-1]) && (alu_wide[W-1] != OP_A[W-1]);
      end
      2'd1: begin
        alu_wide = {1'b0, OP_A} - {1'b0, OP_B};
        alu_c    = alu_wide[W];
        alu_v    = (OP_A[W-1] != OP_B[W-1]) && (alu_wide[W-1] != OP_A[W-1]);
      end
      2'd2: alu_wide = {1'b0, OP_A & OP_B};
      default: alu_wide = {1'b0, OP_A | OP_B};
    endcase
    ALU_RESULT = alu_wide[W-1:0];
    ALU_FLAGS  = {alu_wide[W-1], (alu_wide[W-1:0] == '0), alu_c, alu_v};
  end

  always @(negedge CLK) begin
    if (STATE_LEDS === L_CALC) calc_seen++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       BTN_ENTER = v;
      1:       BTN_UNDO  = v;
      default: BTN_MODE  = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    tick(hold);
    set_btn(which, 1'b0);
    tick(12);
  endtask

  task automatic wait_leds(input string tag, input logic [4:0] want, input int budget);
    int n;
    n = 0;
    while (STATE_LEDS !== want && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(STATE_LEDS), 32'(want));
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb: got empty queue want entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_bin"}, BIN_OUT, e.bin);
      chk({tag, "_flags"}, 32'(FLAGS_OUT), 32'(e.flags));
    end
  endtask

  initial begin
    int c0;
    int lat;

    // Reset with every button held.
    RESET     = 1'b1;
    SW        = '0;
    BTN_ENTER = 1'b1;
    BTN_UNDO  = 1'b1;
    BTN_MODE  = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(1);
    chk("rst_bin",   BIN_OUT, 32'h0);
    chk("rst_hex",   32'(HEX_TRIGGER), 32'd1);
    chk("rst_leds",  32'(STATE_LEDS), 32'(L_A));
    chk("rst_opa",   32'(OP_A), 32'h0);
    chk("rst_flags", 32'(FLAGS_OUT), 32'h0);
    tick(20);
    chk("held_leds", 32'(STATE_LEDS), 32'(L_A));
    chk("held_hex",  32'(HEX_TRIGGER), 32'd1);
    BTN_ENTER = 1'b0;
    BTN_UNDO  = 1'b0;
    BTN_MODE  = 1'b0;
    tick(15);
    chk("release_leds", 32'(STATE_LEDS), 32'(L_A));
    chk("release_hex",  32'(HEX_TRIGGER), 32'd1);

    // Add sequence: 0x12 + 0x30.
    SW = 16'h0012;
    press(0, 10);
    wait_leds("to_b", L_B, 30);
    chk("opa_latched", 32'(OP_A), 32'h12);
    SW = 16'h0030;
    tick(1);
    chk("echo_b", BIN_OUT, 32'h30);

    press(2, 10);
    chk("mode_b_hex", 32'(HEX_TRIGGER), 32'd0);
    chk("mode_b_bin", BIN_OUT, 32'h30);

    press(0, 10);
    wait_leds("to_op", L_OP, 30);
    chk("opb_latched", 32'(OP_B), 32'h30);
    SW = 16'h0005;
    tick(1);
    chk("echo_op", BIN_OUT, 32'h1);

    SW = 16'h0000;
    tick(1);
    c0 = calc_seen;
    sb.push_back('{32'h0000_0042, 4'b0000});
    press(0, 10);
    wait_leds("to_res_add", L_RES, 30);
    chk("calc_one_cycle", 32'(calc_seen - c0), 32'd1);
    tick(1);
    check_result("add");
    chk("opcode_add", 32'(OPCODE), 32'd0);

    press(2, 10);
    chk("mode_res_hex", 32'(HEX_TRIGGER), 32'd1);
    chk("mode_res_bin", BIN_OUT, 32'h42);

    // Undo path.
    press(1, 10);
    wait_leds("undo_to_op", L_OP, 30);
    chk("undo_opa", 32'(OP_A), 32'h12);
    chk("undo_opb", 32'(OP_B), 32'h30);

    BTN_UNDO  = 1'b1;
    BTN_ENTER = 1'b1;
    tick(10);
    BTN_UNDO  = 1'b0;
    BTN_ENTER = 1'b0;
    tick(12);
    wait_leds("both_to_b", L_B, 30);
    tick(10);
    chk("both_settled", 32'(STATE_LEDS), 32'(L_B));

    // Subtract: 0x12 - 0x30 borrows and goes negative.
    SW = 16'h0030;
    press(0, 10);
    wait_leds("to_op_sub", L_OP, 30);
    SW = 16'h0001;
    sb.push_back('{32'h0000_FFE2, 4'b1010});
    press(0, 10);
    wait_leds("to_res_sub", L_RES, 30);
    tick(1);
    check_result("sub");

    // Glitches of DB_CYCLES-1 cycles are filtered.
    for (int k = 0; k < 4; k++) begin
      BTN_ENTER = 1'b1;
      tick(DB - 1);
      BTN_ENTER = 1'b0;
      tick(3);
    end
    tick(10);
    chk("glitch_ignored", 32'(STATE_LEDS), 32'(L_RES));

    // A 7-cycle hold gives one pulse DB_CYCLES+3 cycles after the rise; the
    // state register follows one edge later.
    BTN_ENTER = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == DB + 3) BTN_ENTER = 1'b0;
      if (lat == 0 && STATE_LEDS !== L_RES) lat = i;
    end
    chk("pulse_latency", 32'(lat), 32'(DB + 4));
    tick(15);
    chk("single_pulse", 32'(STATE_LEDS), 32'(L_A));
    chk("clr_opa",   32'(OP_A), 32'h0);
    chk("clr_opb",   32'(OP_B), 32'h0);
    chk("clr_opcode", 32'(OPCODE), 32'h0);
    chk("clr_echo",  BIN_OUT, 32'h1);

    // Reset in the middle of an entry.
    SW = 16'hFFFF;
    press(0, 10);
    wait_leds("mid_to_b", L_B, 30);
    chk("mid_opa", 32'(OP_A), 32'hFFFF);
    press(0, 10);
    wait_leds("mid_to_op", L_OP, 30);
    SW = 16'h1234;
    RESET = 1'b1;
    tick(1);
    chk("midrst_opa",  32'(OP_A), 32'h0);
    chk("midrst_opb",  32'(OP_B), 32'h0);
    chk("midrst_leds", 32'(STATE_LEDS), 32'(L_A));
    chk("midrst_hex",  32'(HEX_TRIGGER), 32'd1);
    RESET = 1'b0;
    tick(1);
    chk("midrst_echo", BIN_OUT, 32'h1234);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_input_sequencer.md
Name: calc_input_sequencer

Overview:
- Upstream control stage of the calculator.
- Debounces the front-panel buttons and steps through operand A, operand B and opcode entry from the switches.
- Drives the combinational ALU operands and opcode, and captures the ALU result and flags.
- Produces the 32-bit value and the hex/decimal select consumed by the display driver (its BIN_IN and HEX_TRIGGER inputs).

Parameters:
- WIDTH, 16, operand/result width in bits (must be at most 32).
- DB_CYCLES, 1000000, consecutive stable cycles a synchronized button must hold before its debounced level changes (10 ms at 100 MHz).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- SW  input  WIDTH  operand/opcode switches; asynchronous to CLK, not debounced.
- BTN_ENTER  input  1  raw button, advance state.
- BTN_UNDO  input  1  raw button, step back one state.
- BTN_MODE  input  1  raw button, toggle hex/decimal display.
- ALU_RESULT  input  WIDTH  combinational ALU result from OP_A/OP_B/OPCODE.
- ALU_FLAGS  input  4  ALU flags {N,Z,C,V}.
- OP_A  output  WIDTH  registered operand A.
- OP_B  output  WIDTH  registered operand B.
- OPCODE  output  2  registered opcode.
- BIN_OUT  output  32  value to display driver.
- HEX_TRIGGER  output  1  1 = hex display, 0 = decimal (BCD) display.
- FLAGS_OUT  output  4  flags captured with the result.
- STATE_LEDS  output  5  one-hot current state {RES,CALC,OP,B,A}.

Behaviour:
- Synchronous reset (RESET=1 at a rising edge) puts every register in a defined state:
  - OP_A=0, OP_B=0, OPCODE=0, result register=0, FLAGS_OUT=0.
  - HEX_TRIGGER=1, state=S_A, STATE_LEDS=5'b00001.
  - Debounce counters=0, debounced levels=0, sync flops=0.
- Reset mid-operation behaves identically; no pulse is generated from a button already held when reset releases until it is released and pressed again.
- Button conditioning, per button:
  - 2-flop synchronizer, then a counter.
  - When the synchronized level differs from the debounced level, the counter increments; when it matches, the counter clears.
  - When the counter reaches DB_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a one-cycle pulse on the next cycle.
  - Raw-high to pulse latency: DB_CYCLES+3 cycles.
  - Glitches shorter than DB_CYCLES produce no pulse.
  - Release produces no pulse.
- MODE pulse toggles HEX_TRIGGER in any state, including S_CALC.
- State machine (ENTER / UNDO pulses):
  - S_A: ENTER latches OP_A<=SW, goes to S_B. UNDO has no effect.
  - S_B: ENTER latches OP_B<=SW, goes to S_OP. UNDO goes to S_A (OP_A kept).
  - S_OP: ENTER latches OPCODE<=SW[1:0], goes to S_CALC. UNDO goes to S_B.
  - S_CALC: transient, exactly 1 cycle. Captures result<=ALU_RESULT and FLAGS_OUT<=ALU_FLAGS, goes to S_RES. Buttons are ignored except MODE.
  - S_RES: ENTER clears OP_A, OP_B, OPCODE and the result, goes to S_A. UNDO goes to S_OP with all values kept.
- ENTER and UNDO pulses in the same cycle: UNDO wins, ENTER is discarded.
- BIN_OUT (registered, updated every cycle):
  - S_A, S_B: {zeros, SW}, i.e. a live switch echo.
  - S_OP: {30'b0, SW[1:0]}.
  - S_CALC, S_RES: {zeros, result}.
  - Always zero-extended from WIDTH to 32.
  - 1-cycle latency from SW or state change.
- FLAGS_OUT holds its last captured value until the next capture or a clear.

Test Plan (DB_CYCLES=4, WIDTH=16):
- Reset check: assert RESET for 2 cycles with all buttons held high, then release -> BIN_OUT=0, HEX_TRIGGER=1, STATE_LEDS=00001; no state change until the buttons are released and pressed again.
- Full add sequence with the ALU model implementing opcode 0 = add:
  - SW=0x0012, press ENTER for 10 cycles -> OP_A=0x0012.
  - SW=0x0030, ENTER -> OP_B=0x0030.
  - SW=0x0000, ENTER -> BIN_OUT=0x00000042 one cycle after S_CALC, Z flag 0, STATE_LEDS=10000.
- Glitch filtering: ENTER pulses high for 3 cycles, repeated -> no state change; a 4+3 cycle hold -> exactly one pulse, at DB_CYCLES+3=7 cycles after the rise.
- Undo path: from S_RES, press UNDO -> S_OP with OP_A/OP_B kept. Then press UNDO and ENTER together -> goes to S_B only.
- Mode toggle: press MODE in S_B and again in S_RES -> HEX_TRIGGER 1->0->1; BIN_OUT unaffected.
- Mid-operation reset: RESET asserted in S_OP with OP_A=0xFFFF -> next cycle OP_A=0, state S_A, BIN_OUT reflects SW.
